// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT engine.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } fft_state_t;

  localparam real TWO_PI = 6.283185307179586;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int bitrev(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) begin
      r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

  function automatic real tw_scale(input int frac);
    real s;
    s = 1.0;
    for (int i = 0; i < frac; i++) begin
      s = s * 2.0;
    end
    return s;
  endfunction

  // Round half away from zero so the ROM is symmetric about both axes.
  function automatic int round_real(input real r);
    real a;
    if (r >= 0.0) begin
      a = $floor(r + 0.5);
    end else begin
      a = -$floor(-r + 0.5);
    end
    return int'(a);
  endfunction

  // Entry m of the N/2-deep twiddle table: round(2^frac * cos(2*pi*m/n)).
  function automatic int tw_cos(input int m, input int n, input int frac);
    return round_real($cos(TWO_PI * m / n) * tw_scale(frac));
  endfunction

  // Entry m of the N/2-deep twiddle table: round(-2^frac * sin(2*pi*m/n)).
  function automatic int tw_nsin(input int m, input int n, input int frac);
    return round_real(-$sin(TWO_PI * m / n) * tw_scale(frac));
  endfunction

endpackage

// File: rtl/fft_bf_unit.sv
// Combinational radix-2 DIT butterfly: y0 = a + b*w, y1 = a - b*w, optional /2 per stage.
module fft_bf_unit #(
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8,
  parameter int SCALE   = 0
) (
  input  logic signed [DATA_W-1:0]  a_re,
  input  logic signed [DATA_W-1:0]  a_im,
  input  logic signed [DATA_W-1:0]  b_re,
  input  logic signed [DATA_W-1:0]  b_im,
  input  logic signed [TW_FRAC+1:0] w_re,
  input  logic signed [TW_FRAC+1:0] w_im,
  output logic signed [DATA_W-1:0]  y0_re,
  output logic signed [DATA_W-1:0]  y0_im,
  output logic signed [DATA_W-1:0]  y1_re,
  output logic signed [DATA_W-1:0]  y1_im
);

  localparam int PW = DATA_W + TW_FRAC + 4;

  logic signed [PW-1:0] t_re_s;
  logic signed [PW-1:0] t_im_s;
  logic signed [PW-1:0] s0_re_s;
  logic signed [PW-1:0] s0_im_s;
  logic signed [PW-1:0] s1_re_s;
  logic signed [PW-1:0] s1_im_s;
  logic                 unused_s;

  // Full-precision complex product, floor-shifted back to sample scale, then add/sub.
  always_comb begin
    t_re_s = ((PW'(b_re) * PW'(w_re)) - (PW'(b_im) * PW'(w_im))) >>> TW_FRAC;
    t_im_s = ((PW'(b_re) * PW'(w_im)) + (PW'(b_im) * PW'(w_re))) >>> TW_FRAC;
    if (SCALE != 0) begin
      s0_re_s = (PW'(a_re) + t_re_s) >>> 1;
      s0_im_s = (PW'(a_im) + t_im_s) >>> 1;
      s1_re_s = (PW'(a_re) - t_re_s) >>> 1;
      s1_im_s = (PW'(a_im) - t_im_s) >>> 1;
    end else begin
      s0_re_s = PW'(a_re) + t_re_s;
      s0_im_s = PW'(a_im) + t_im_s;
      s1_re_s = PW'(a_re) - t_re_s;
      s1_im_s = PW'(a_im) - t_im_s;
    end
  end

  // Dropping the upper bits is the intended wrap-on-overflow behaviour.
  assign y0_re = s0_re_s[DATA_W-1:0];
  assign y0_im = s0_im_s[DATA_W-1:0];
  assign y1_re = s1_re_s[DATA_W-1:0];
  assign y1_im = s1_im_s[DATA_W-1:0];

  assign unused_s = ^{s0_re_s[PW-1:DATA_W], s0_im_s[PW-1:DATA_W],
                      s1_re_s[PW-1:DATA_W], s1_im_s[PW-1:DATA_W]};

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative in-place N-point radix-2 DIT FFT/IFFT with streaming valid/ready load and unload.
module fft_radix2_iter
  import fft_pkg::*;
#(
  parameter int N       = 8,
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8,
  parameter int SCALE   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_real,
  input  logic signed [DATA_W-1:0]  in_imag,
  input  logic                      inverse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_real,
  output logic signed [DATA_W-1:0]  out_imag,
  output logic [clog2(N)-1:0]       out_index,
  output logic                      out_last,
  output logic                      busy
);

  localparam int LG  = clog2(N);
  localparam int TWW = TW_FRAC + 2;
  localparam int SW  = 3;
  localparam logic [LG-1:0] IDX_FIRST = '0;
  localparam logic [LG-1:0] IDX_LAST  = LG'(N - 1);
  localparam logic [LG-2:0] BF_LAST   = (LG-1)'(N / 2 - 1);
  localparam logic [SW-1:0] ST_LAST   = SW'(LG - 1);

  fft_state_t               state_r;
  logic [LG-1:0]            cnt_r;
  logic [LG-2:0]            bfly_r;
  logic [SW-1:0]            stage_r;
  logic                     inv_r;
  logic signed [DATA_W-1:0] mem_re_r [N];
  logic signed [DATA_W-1:0] mem_im_r [N];

  logic signed [TWW-1:0]    tw_re_rom_s [N/2];
  logic signed [TWW-1:0]    tw_im_rom_s [N/2];

  logic [LG-2:0]            hmask_s;
  logic [LG-2:0]            j_s;
  logic [LG-1:0]            h_s;
  logic [LG-1:0]            p_s;
  logic [LG-1:0]            q_s;
  logic [LG-2:0]            tw_idx_s;
  logic [LG-1:0]            br_s;
  logic [LG-1:0]            nxt_s;
  logic signed [TWW-1:0]    w_re_s;
  logic signed [TWW-1:0]    w_im_s;
  logic signed [DATA_W-1:0] y0_re_s;
  logic signed [DATA_W-1:0] y0_im_s;
  logic signed [DATA_W-1:0] y1_re_s;
  logic signed [DATA_W-1:0] y1_im_s;

  for (genvar gi = 0; gi < N / 2; gi++) begin : g_rom
    localparam int TW_RE = tw_cos(gi, N, TW_FRAC);
    localparam int TW_IM = tw_nsin(gi, N, TW_FRAC);
    assign tw_re_rom_s[gi] = TWW'(TW_RE);
    assign tw_im_rom_s[gi] = TWW'(TW_IM);
  end

  // Butterfly operand addresses and twiddle index for (stage_r, bfly_r); p = g*2h + j, q = p + h.
  always_comb begin
    hmask_s  = ~({(LG-1){1'b1}} << stage_r);
    j_s      = bfly_r & hmask_s;
    h_s      = LG'(1) << stage_r;
    p_s      = {bfly_r & ~hmask_s, 1'b0} | {1'b0, j_s};
    q_s      = p_s + h_s;
    tw_idx_s = j_s << (ST_LAST - stage_r);
    br_s     = LG'(bitrev(int'(cnt_r), LG));
    nxt_s    = cnt_r + LG'(1);
    w_re_s   = tw_re_rom_s[tw_idx_s];
    if (inv_r) begin
      w_im_s = -tw_im_rom_s[tw_idx_s];
    end else begin
      w_im_s = tw_im_rom_s[tw_idx_s];
    end
  end

  fft_bf_unit #(
    .DATA_W (DATA_W),
    .TW_FRAC(TW_FRAC),
    .SCALE  (SCALE)
  ) u_bf (
    .a_re (mem_re_r[p_s]),
    .a_im (mem_im_r[p_s]),
    .b_re (mem_re_r[q_s]),
    .b_im (mem_im_r[q_s]),
    .w_re (w_re_s),
    .w_im (w_im_s),
    .y0_re(y0_re_s),
    .y0_im(y0_im_s),
    .y1_re(y1_re_s),
    .y1_im(y1_im_s)
  );

  // Register file: bit-reversed writes during load, butterfly write-back during compute.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_re_r[i] <= '0;
        mem_im_r[i] <= '0;
      end
    end else if ((state_r == LOAD) && in_valid) begin
      mem_re_r[br_s] <= in_real;
      mem_im_r[br_s] <= in_imag;
    end else if (state_r == COMPUTE) begin
      mem_re_r[p_s] <= y0_re_s;
      mem_im_r[p_s] <= y0_im_s;
      mem_re_r[q_s] <= y1_re_s;
      mem_im_r[q_s] <= y1_im_s;
    end
  end

  // Frame sequencer with registered handshake and output signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= LOAD;
      cnt_r     <= '0;
      bfly_r    <= '0;
      stage_r   <= '0;
      inv_r     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid) begin
            if (cnt_r == IDX_FIRST) begin
              inv_r <= inverse;
            end
            if (cnt_r == IDX_LAST) begin
              cnt_r    <= '0;
              state_r  <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt_r <= nxt_s;
            end
          end
        end
        COMPUTE: begin
          if (bfly_r == BF_LAST) begin
            bfly_r <= '0;
            if (stage_r == ST_LAST) begin
              // Address 0 is last written by the first butterfly of the final stage, so it is settled here.
              stage_r   <= '0;
              state_r   <= UNLOAD;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_index <= IDX_FIRST;
              out_real  <= mem_re_r[IDX_FIRST];
              out_imag  <= mem_im_r[IDX_FIRST];
            end else begin
              stage_r <= stage_r + SW'(1);
            end
          end else begin
            bfly_r <= bfly_r + (LG-1)'(1);
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (cnt_r == IDX_LAST) begin
              cnt_r     <= '0;
              state_r   <= LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_index <= '0;
              out_real  <= '0;
              out_imag  <= '0;
            end else begin
              cnt_r     <= nxt_s;
              out_index <= nxt_s;
              out_real  <= mem_re_r[nxt_s];
              out_imag  <= mem_im_r[nxt_s];
              out_last  <= (nxt_s == IDX_LAST);
            end
          end
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed scoreboard bench for fft_radix2_iter (N=8), with a SCALE=1 twin sharing the stimulus.
module tb_fft_radix2_iter;

  localparam int N = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               inverse;
  logic               out_ready;
  logic               in_ready, out_valid, out_last, busy;
  logic signed [15:0] out_real, out_imag;
  logic [2:0]         out_index;
  logic               in_ready_s, out_valid_s, out_last_s, busy_s;
  logic signed [15:0] out_real_s, out_imag_s;
  logic [2:0]         out_index_s;

  always #5 clk = ~clk;

  fft_radix2_iter #(.N(8), .DATA_W(16), .TW_FRAC(8), .SCALE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
    .out_imag(out_imag), .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  fft_radix2_iter #(.N(8), .DATA_W(16), .TW_FRAC(8), .SCALE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_real(out_real_s),
    .out_imag(out_imag_s), .out_index(out_index_s), .out_last(out_last_s), .busy(busy_s)
  );

  typedef struct {
    int re;
    int im;
    int tol;
    int re_s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xr[N];
  int   xi[N];

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((tol == 0) ? (obs === exp) : (((obs - exp) <= tol) && ((exp - obs) <= tol)))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_bin(input int re, input int im, input int tol, input int re_s);
    exp_t e;
    e.re   = re;
    e.im   = im;
    e.tol  = tol;
    e.re_s = re_s;
    sb.push_back(e);
  endtask

  // inverse is valid only with sample 0; later samples carry the opposite value.
  task automatic send_frame(input bit inv, input int maxgap);
    int w;
    for (int n = 0; n < N; n++) begin
      in_valid = 1'b1;
      in_real  = 16'(xr[n]);
      in_imag  = 16'(xi[n]);
      inverse  = (n == 0) ? inv : ~inv;
      w = 0;
      while (!in_ready && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      chk("in_ready_wait", int'(w < 200), 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      inverse  = 1'b0;
      if (maxgap > 0) begin
        repeat ($urandom_range(maxgap, 0)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic recv_frame(input int stall_bin, input bit chk_s);
    exp_t e;
    int   w;
    int   hr, hi, hx;
    for (int k = 0; k < N; k++) begin
      out_ready = 1'b1;
      w = 0;
      while (!out_valid && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      chk("out_valid", int'(out_valid), 1, 0);
      chk("sb_nonempty", int'(sb.size() > 0), 1, 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("bin%0d_index", k), int'(out_index), k, 0);
        chk($sformatf("bin%0d_last", k), int'(out_last), int'(k == N - 1), 0);
        chk($sformatf("bin%0d_re", k), int'(out_real), e.re, e.tol);
        chk($sformatf("bin%0d_im", k), int'(out_imag), e.im, e.tol);
        if (chk_s) begin
          chk($sformatf("scaled_bin%0d_valid", k), int'(out_valid_s), 1, 0);
          chk($sformatf("scaled_bin%0d_index", k), int'(out_index_s), k, 0);
          chk($sformatf("scaled_bin%0d_last", k), int'(out_last_s), int'(k == N - 1), 0);
          chk($sformatf("scaled_bin%0d_re", k), int'(out_real_s), e.re_s, 0);
          chk($sformatf("scaled_bin%0d_im", k), int'(out_imag_s), 0, 0);
        end
      end
      if (k == stall_bin) begin
        out_ready = 1'b0;
        hr = int'(out_real);
        hi = int'(out_imag);
        hx = int'(out_index);
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall_valid", int'(out_valid), 1, 0);
          chk("stall_re", int'(out_real), hr, 0);
          chk("stall_im", int'(out_imag), hi, 0);
          chk("stall_index", int'(out_index), hx, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("post_unload_in_ready", int'(in_ready), 1, 0);
    chk("post_unload_out_valid", int'(out_valid), 0, 0);
    chk("post_unload_busy", int'(busy), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    inverse   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_out_last", int'(out_last), 0, 0);
    chk("rst_out_index", int'(out_index), 0, 0);
    chk("rst_out_real", int'(out_real), 0, 0);
    chk("rst_out_imag", int'(out_imag), 0, 0);
    chk("rst_scaled_in_ready", int'(in_ready_s), 1, 0);
    chk("rst_scaled_busy", int'(busy_s), 0, 0);
    rst = 1'b0;

    // Impulse: flat spectrum of 100.
    for (int n = 0; n < N; n++) begin xr[n] = (n == 0) ? 100 : 0; xi[n] = 0; end
    for (int k = 0; k < N; k++) push_bin(100, 0, 0, 0);
    send_frame(1'b0, 0);
    recv_frame(-1, 1'b0);

    // DC: X[0]=80, compute takes 12 cycles after the last input handshake.
    for (int n = 0; n < N; n++) begin xr[n] = 10; xi[n] = 0; end
    for (int k = 0; k < N; k++) push_bin((k == 0) ? 80 : 0, 0, 0, 0);
    send_frame(1'b0, 0);
    chk("compute_in_ready", int'(in_ready), 0, 0);
    chk("compute_busy", int'(busy), 1, 0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("compute_cycles", cyc, 12, 0);
    recv_frame(-1, 1'b0);

    // Alternating sign: X[4]=80 unscaled, 10 on the SCALE=1 twin.
    for (int n = 0; n < N; n++) begin xr[n] = (n % 2 == 0) ? 10 : -10; xi[n] = 0; end
    for (int k = 0; k < N; k++) push_bin((k == 4) ? 80 : 0, 0, 0, (k == 4) ? 10 : 0);
    send_frame(1'b0, 0);
    recv_frame(-1, 1'b1);

    // Forward of x[1]=64: X[k] = 64*exp(-j*pi*k/4).
    for (int n = 0; n < N; n++) begin xr[n] = (n == 1) ? 64 : 0; xi[n] = 0; end
    push_bin(64, 0, 0, 0);    push_bin(45, -45, 1, 0);
    push_bin(0, -64, 0, 0);   push_bin(-45, -45, 1, 0);
    push_bin(-64, 0, 0, 0);   push_bin(-45, 45, 1, 0);
    push_bin(0, 64, 0, 0);    push_bin(45, 45, 1, 0);
    send_frame(1'b0, 0);
    recv_frame(-1, 1'b0);

    // Inverse of that spectrum returns 8*x: 512 at n=1.
    xr = '{64, 45, 0, -45, -64, -45, 0, 45};
    xi = '{0, -45, -64, -45, 0, 45, 64, 45};
    for (int k = 0; k < N; k++) push_bin((k == 1) ? 512 : 0, 0, 2, 0);
    send_frame(1'b1, 0);
    recv_frame(-1, 1'b0);

    // Backpressure: random input gaps and a 5-cycle stall on bin 3.
    for (int n = 0; n < N; n++) begin xr[n] = (n == 1) ? 64 : 0; xi[n] = 0; end
    push_bin(64, 0, 0, 0);    push_bin(45, -45, 1, 0);
    push_bin(0, -64, 0, 0);   push_bin(-45, -45, 1, 0);
    push_bin(-64, 0, 0, 0);   push_bin(-45, 45, 1, 0);
    push_bin(0, 64, 0, 0);    push_bin(45, 45, 1, 0);
    send_frame(1'b0, 3);
    recv_frame(3, 1'b0);

    // Reset in the middle of compute aborts the frame.
    for (int n = 0; n < N; n++) begin xr[n] = 10; xi[n] = 0; end
    send_frame(1'b0, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_busy", int'(busy), 0, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0, 0);
    for (int k = 0; k < N; k++) push_bin((k == 0) ? 80 : 0, 0, 0, 0);
    send_frame(1'b0, 0);
    recv_frame(-1, 1'b0);

    chk("sb_drained", sb.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
